dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 31 +++
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared constants for the data-memory arbiter: FSM state
//               encodings, port identifiers, sign_mask field positions and
//               the LED byte address.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_BUSY  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Requester identifiers held in the grant register
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // sign_mask field positions
  localparam int MASK_SIGNED_BIT = 3;
  localparam int MASK_WORD_BIT   = 2;
  localparam int MASK_HALF_BIT   = 1;

  // Memory-mapped LED register; treated like any other address
  localparam logic [31:0] LED_ADDR = 32'h0000_2000;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port (cpu / dbg) arbiter in front of a single data memory
//               that signals completion through a clk_stall busy flag.
//               One access is outstanding at a time: IDLE -> ISSUE -> BUSY ->
//               DONE. Ties go to cpu unless DMEM_ARB_ROUND_ROBIN_EN is
//               defined, in which case the port not granted last wins.
// Config      : `define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              dbg_req,
  input  logic              cpu_we,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [3:0]        cpu_mask,
  input  logic [3:0]        dbg_mask,
  output logic              cpu_ack,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [3:0]        mem_sign_mask,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_clk_stall
);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_gnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_mask;
  logic                r_seen_stall;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dbg_rdata;
  logic                w_any_req;
  logic                w_win;
  logic                w_done_entry;

  assign w_any_req = cpu_req | dbg_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // High when dbg should win the next tie (cpu was granted last)
  logic r_prio_dbg;

  // Tie goes to the port not granted last; a lone request always wins
  always_comb begin
    w_win = PORT_CPU;
    if (cpu_req && dbg_req) w_win = r_prio_dbg;
    else if (dbg_req)       w_win = PORT_DBG;
  end

  // Pointer flips toward the other port on every grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_dbg <= 1'b0;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_prio_dbg <= (w_win == PORT_CPU);
    end
  end
`else
  // Fixed priority: cpu wins whenever it requests
  always_comb begin
    w_win = cpu_req ? PORT_CPU : PORT_DBG;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_next_state = ST_ISSUE;
      ST_ISSUE: w_next_state = ST_BUSY;
      ST_BUSY:  if (r_seen_stall && !mem_clk_stall) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Load data is captured on entry to DONE so rdata is valid alongside ack
  assign w_done_entry = (r_state == ST_BUSY) && (w_next_state == ST_DONE);

  // Grant register, stall-seen tracking and per-port read-data holding
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt        <= PORT_CPU;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mask       <= '0;
      r_seen_stall <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any_req) begin
        r_gnt   <= w_win;
        r_we    <= (w_win == PORT_DBG) ? dbg_we    : cpu_we;
        r_addr  <= (w_win == PORT_DBG) ? dbg_addr  : cpu_addr;
        r_wdata <= (w_win == PORT_DBG) ? dbg_wdata : cpu_wdata;
        r_mask  <= (w_win == PORT_DBG) ? dbg_mask  : cpu_mask;
      end
      if (r_state != ST_BUSY)    r_seen_stall <= 1'b0;
      else if (mem_clk_stall)    r_seen_stall <= 1'b1;
      if (w_done_entry && !r_we) begin
        if (r_gnt == PORT_DBG) r_dbg_rdata <= mem_read_data;
        else                   r_cpu_rdata <= mem_read_data;
      end
    end
  end

  // Outputs decoded from state and the grant register
  always_comb begin
    mem_memread    = (r_state == ST_ISSUE) && !r_we;
    mem_memwrite   = (r_state == ST_ISSUE) &&  r_we;
    cpu_ack        = (r_state == ST_DONE) && (r_gnt == PORT_CPU);
    dbg_ack        = (r_state == ST_DONE) && (r_gnt == PORT_DBG);
    cpu_stall      = cpu_req && !cpu_ack;
    mem_addr       = r_addr;
    mem_write_data = r_wdata;
    mem_sign_mask  = r_mask;
    cpu_rdata      = r_cpu_rdata;
    dbg_rdata      = r_dbg_rdata;
  end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a clk_stall memory
//               model (stores busy one cycle, loads two).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 0, dbg_req = 0, cpu_we = 0, dbg_we = 0;
  logic [31:0] cpu_addr = 0, dbg_addr = 0, cpu_wdata = 0, dbg_wdata = 0;
  logic [3:0]  cpu_mask = 0, dbg_mask = 0;
  logic        cpu_ack, dbg_ack, cpu_stall, mem_memread, mem_memwrite;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_write_data;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .dbg_req(dbg_req), .cpu_we(cpu_we), .dbg_we(dbg_we),
    .cpu_addr(cpu_addr), .dbg_addr(dbg_addr),
    .cpu_wdata(cpu_wdata), .dbg_wdata(dbg_wdata),
    .cpu_mask(cpu_mask), .dbg_mask(dbg_mask),
    .cpu_ack(cpu_ack), .dbg_ack(dbg_ack),
    .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem [logic [31:0]];
  int          r_busy_cnt;
  always @(posedge clk) begin
    if (rst) begin
      mem_clk_stall <= 1'b0;
      r_busy_cnt    <= 0;
    end else if (mem_memread || mem_memwrite) begin
      mem_clk_stall <= 1'b1;
      r_busy_cnt    <= mem_memread ? 2 : 1;
      if (mem_memwrite) mem[{mem_addr[31:2], 2'b00}] = mem_write_data;
      else mem_read_data <= mem.exists({mem_addr[31:2], 2'b00}) ? mem[{mem_addr[31:2], 2'b00}] : 32'h0;
    end else if (r_busy_cnt > 0) begin
      r_busy_cnt <= r_busy_cnt - 1;
      if (r_busy_cnt == 1) mem_clk_stall <= 1'b0;
    end
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    int          req_cyc;
    int          lat;
  } item_t;
  item_t sb[$];

  // ---------------- monitor ----------------
  int strb_cnt = 0;
  bit last_we  = 0;
  always @(negedge clk) begin
    item_t it;
    if (rst) begin
      strb_cnt = 0;
    end else begin
      if (mem_memread && mem_memwrite) chk("both_strobes", 1, 0);
      if (mem_memread || mem_memwrite) begin
        strb_cnt++;
        last_we = mem_memwrite;
      end
      if (cpu_ack || dbg_ack) begin
        if (cpu_ack && dbg_ack) chk("dual_ack", 1, 0);
        else if (sb.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          it = sb.pop_front();
          chk("ack_port", dbg_ack, it.port);
          chk("rdata", it.port ? dbg_rdata : cpu_rdata, it.rdata);
          chk("mem_addr", mem_addr, it.addr);
          chk("mem_wdata", mem_write_data, it.wdata);
          chk("mem_mask", mem_sign_mask, it.mask);
          chk("strobe_count", strb_cnt, 1);
          chk("strobe_kind", last_we, it.we);
          if (it.lat != 0) chk("latency", cyc - it.req_cyc, it.lat);
        end
        strb_cnt = 0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};

  task automatic drive(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
    if (port) begin
      dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_mask = mask;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_mask = mask;
    end
  endtask

  task automatic push(input bit port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask,
                      input logic [31:0] ld_val, input int lat);
    item_t it;
    if (!we) exp_rdata[port] = ld_val;
    it.port = port; it.we = we; it.addr = addr; it.wdata = wdata; it.mask = mask;
    it.rdata = exp_rdata[port]; it.req_cyc = cyc; it.lat = lat;
    sb.push_back(it);
  endtask

  // Wait for this port's ack, checking cpu_stall each cycle; then drop reqs
  task automatic wait_ack(input bit port);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = port ? dbg_ack : cpu_ack;
      chk("cpu_stall", cpu_stall, cpu_req & ~(got & ~port));
    end
    if (!got) chk("ack_timeout", 0, 1);
    @(posedge clk); #1;
    cpu_req = 0; dbg_req = 0;
  endtask

  task automatic single(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        input logic [31:0] ld_val, input int lat);
    @(posedge clk); #1;
    drive(port, we, addr, wdata, mask);
    push(port, we, addr, wdata, mask, ld_val, lat);
    wait_ack(port);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cpu_ack"}, cpu_ack, 0);
    chk({tag, "_dbg_ack"}, dbg_ack, 0);
    chk({tag, "_strobes"}, {mem_memread, mem_memwrite}, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_dbg_rdata"}, dbg_rdata, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_write_data, 0);
    chk({tag, "_mem_mask"}, mem_sign_mask, 0);
    chk({tag, "_cpu_stall"}, cpu_stall, 0);
    chk({tag, "_state"}, dut.r_state, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mem[32'h1004] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 0;

    // CPU word load: 5-cycle latency
    single(0, 0, 32'h1004, 32'h0, 4'b0100, 32'hDEAD_BEEF, 5);

    // dbg byte store: 4-cycle latency, cpu_stall stays low (checked in wait_ack)
    single(1, 1, 32'h1001, 32'h0000_00AA, 4'b0000, 32'h0, 4);

    // Two back-to-back ties; the loser is abandoned each round
    for (int r = 0; r < 2; r++) begin
      bit w;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      w = (r == 1);
`else
      w = 1'b0;
`endif
      @(posedge clk); #1;
      drive(0, 1, 32'h3000, 32'h11, 4'b0100);
      drive(1, 1, 32'h3004, 32'h22, 4'b0100);
      if (w) push(1, 1, 32'h3004, 32'h22, 4'b0100, 32'h0, 4);
      else   push(0, 1, 32'h3000, 32'h11, 4'b0100, 32'h0, 4);
      wait_ack(w);
      @(posedge clk);
    end

    // LED store passes through unmodified
    single(0, 1, LED_ADDR, 32'h1, 4'b0100, 32'h0, 4);

    // cpu_req dropped mid-BUSY: access still completes, reading back the LED
    @(posedge clk); #1;
    drive(0, 0, LED_ADDR, 32'h0, 4'b0100);
    push(0, 0, LED_ADDR, 32'h0, 4'b0100, 32'h1, 5);
    repeat (3) @(posedge clk);
    #1 cpu_req = 0;
    wait_ack(0);
    repeat (8) @(posedge clk);
    chk("no_extra_strobe", strb_cnt, 0);

    // Reset pulsed during BUSY of a load
    @(posedge clk); #1;
    drive(0, 0, 32'h1004, 32'h0, 4'b0100);
    repeat (3) @(posedge clk);
    #1;
    cpu_req = 0;
    rst = 1;
    @(posedge clk); #1;
    check_all_zero("midrst");
    rst = 0;
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;

    // Subsequent request completes normally
    single(0, 0, 32'h1004, 32'h0, 4'b0100, 32'hDEAD_BEEF, 5);

    repeat (10) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("idle_strobes", strb_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
